// File: rtl/multi_spi_pkg.sv
// Shared lane-mode encodings, FSM state type and lane-width helper for the
// multi-lane SPI transmitter.
package multi_spi_pkg;

    localparam logic [1:0] MODE_X1   = 2'b00;
    localparam logic [1:0] MODE_X2   = 2'b01;
    localparam logic [1:0] MODE_RSVD = 2'b10;
    localparam logic [1:0] MODE_X4   = 2'b11;

    typedef enum logic {IDLE, SHIFT} state_t;

    // The reserved encoding maps to 1 so callers never divide by zero.
    function automatic int unsigned lanes_for_mode(input logic [1:0] mode);
        case (mode)
            MODE_X2: return 2;
            MODE_X4: return 4;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/multi_spi_tx.sv
// Multi-lane SPI shift-out transmitter.
// Serialises one word MSB-first over 1, 2 or 4 lanes, framed by writeSelect.
module multi_spi_tx
    import multi_spi_pkg::*;
#(
    parameter int   REGSIZE    = 8,
    parameter logic SELECTCODE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [REGSIZE-1:0] load_data,
    input  logic [1:0]         load_mode,
    output logic [3:0]         O,
    output logic [1:0]         S,
    output logic               writeSelect,
    output logic               done,
    output logic               err
);

    localparam int CW = $clog2(REGSIZE) + 1;

    state_t             state;
    logic [REGSIZE-1:0] shreg;
    logic [CW-1:0]      cnt;
    logic [1:0]         mode_q;
    logic               is_last;
    logic               accept;

    function automatic logic [CW-1:0] last_idx(input logic [1:0] m);
        return CW'(REGSIZE / lanes_for_mode(m) - 1);
    endfunction

    function automatic logic [3:0] beat_bits(input logic [REGSIZE-1:0] d, input logic [1:0] m);
        case (m)
            MODE_X2: return {2'b00, d[REGSIZE-1 -: 2]};
            MODE_X4: return d[REGSIZE-1 -: 4];
            default: return {3'b000, d[REGSIZE-1]};
        endcase
    endfunction

    function automatic logic [REGSIZE-1:0] shift_out(input logic [REGSIZE-1:0] d, input logic [1:0] m);
        case (m)
            MODE_X2: return d << 2;
            MODE_X4: return d << 4;
            default: return d << 1;
        endcase
    endfunction

    // Handshake: a word moves when load_valid and load_ready are both high on a
    // rising clk edge. load_ready is combinational so a new word can be taken on
    // the final beat of the current one, giving gapless back-to-back frames.
    assign is_last    = (state == SHIFT) && (cnt == last_idx(mode_q));
    assign load_ready = rst_n && ((state == IDLE) || is_last);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            mode_q      <= MODE_X1;
            O           <= 4'h0;
            S           <= 2'b00;
            writeSelect <= ~SELECTCODE;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (accept && load_mode != MODE_RSVD) begin
                // The first beat goes straight onto the lanes; shreg keeps the remainder.
                state       <= SHIFT;
                mode_q      <= load_mode;
                cnt         <= '0;
                O           <= beat_bits(load_data, load_mode);
                shreg       <= shift_out(load_data, load_mode);
                S           <= load_mode;
                writeSelect <= SELECTCODE;
                done        <= (last_idx(load_mode) == '0);
            end else if (accept || is_last) begin
                state       <= IDLE;
                cnt         <= '0;
                O           <= 4'h0;
                S           <= 2'b00;
                writeSelect <= ~SELECTCODE;
                err         <= accept;
            end else if (state == SHIFT) begin
                cnt   <= cnt + 1'b1;
                O     <= beat_bits(shreg, mode_q);
                shreg <= shift_out(shreg, mode_q);
                done  <= ((cnt + 1'b1) == last_idx(mode_q));
            end
        end
    end

endmodule
